// File: rtl/led_axil_arb_pkg.sv
// Shared types and constants for the LED AXI4-Lite round-robin arbiter.
// Imported by the arbiter top and its grant sub-module.
package led_axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access for every beat we issue.
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/led_axil_rr_arbiter_rr_grant.sv
// Round-robin grant selection: searches upward from the last winner + 1,
// wrapping modulo NUM_REQ, and holds the registered last-winner pointer.
module rr_grant #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  input  logic [IDX_W-1:0]   update_idx,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant_onehot
);

  logic [IDX_W-1:0] last_grant;

  // Reset to the highest index so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (update) begin
      last_grant <= update_idx;
    end
  end

  always_comb begin
    int               k;
    logic [IDX_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    k           = 0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k    = (int'(last_grant) + i) % NUM_REQ;
      cand = IDX_W'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (grant_valid) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/led_axil_rr_arbiter.sv
// Shares one AXI4-Lite master port between NUM_REQ command requesters,
// running one complete write or read per grant in round-robin order.
module led_axil_rr_arbiter
  import led_axil_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,

  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]          req_wstrb,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          busy,

  output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  state_t                 state;
  state_t                 state_next;

  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]     grant_onehot;

  logic [IDX_W-1:0]       cur_idx;
  logic [NUM_REQ-1:0]     cur_onehot;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH-1:0]  cmd_wdata;
  logic [STRB_W-1:0]      cmd_wstrb;

  logic                   aw_done;
  logic                   w_done;
  logic                   accept;
  logic                   b_hs;
  logic                   r_hs;
  logic                   rsp_fire;

  // Accepting during reset would lose the command, so reset masks the grant.
  assign accept   = (state == IDLE) && grant_valid && !ARESET;
  assign b_hs     = (state == WR_RESP) && M_AXI_BVALID;
  assign r_hs     = (state == RD_DATA) && M_AXI_RVALID;
  assign rsp_fire = b_hs || r_hs;

  rr_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_grant (
    .clk          (ACLK),
    .rst          (ARESET),
    .req          (req_valid),
    .update       (rsp_fire),
    .update_idx   (cur_idx),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = req_write[grant_idx] ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) state_next = IDLE;
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) state_next = RD_DATA;
      end
      RD_DATA: begin
        if (M_AXI_RVALID) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    req_ready     = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      IDLE:         if (accept) req_ready = grant_onehot;
      WR_ADDR_DATA: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
      end
      WR_RESP:      M_AXI_BREADY  = 1'b1;
      RD_ADDR:      M_AXI_ARVALID = 1'b1;
      RD_DATA:      M_AXI_RREADY  = 1'b1;
      default:      ;
    endcase
  end

  // The response cycle is already back in IDLE, so rsp_valid extends busy.
  assign busy = (state != IDLE) || (|rsp_valid);

  always_comb begin
    cur_onehot          = '0;
    cur_onehot[cur_idx] = 1'b1;
  end

  // NOTE: command payload registers carry no reset; they are only observed
  // after an accept has loaded them, so resetting them buys nothing.
  always_ff @(posedge ACLK) begin
    if (accept) begin
      cur_idx   <= grant_idx;
      cmd_addr  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      cmd_wdata <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      cmd_wstrb <= req_wstrb[grant_idx*STRB_W +: STRB_W];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
    end else begin
      rsp_valid <= '0;
      if (accept) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      // AW and W retire independently; each VALID drops on its own handshake.
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
      if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
      if (b_hs) begin
        rsp_valid <= cur_onehot;
        rsp_resp  <= M_AXI_BRESP;
        rsp_rdata <= '0;
      end
      if (r_hs) begin
        rsp_valid <= cur_onehot;
        rsp_resp  <= M_AXI_RRESP;
        rsp_rdata <= M_AXI_RDATA;
      end
    end
  end

  assign M_AXI_AWADDR = cmd_addr;
  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_WDATA  = cmd_wdata;
  assign M_AXI_WSTRB  = cmd_wstrb;
  assign M_AXI_ARADDR = cmd_addr;
  assign M_AXI_ARPROT = PROT_DEFAULT;

endmodule

// File: tb/tb_led_axil_rr_arbiter.sv
// Directed bench for led_axil_rr_arbiter with a small LED register slave model
// (4 x 32-bit registers) that can stall AW, withhold B and inject read errors.
module tb_led_axil_rr_arbiter;

  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            areset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*4-1:0] req_wstrb;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            busy;

  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [3:0]      wstrb;
  logic            wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid, arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid, rready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_axil_rr_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .ACLK(clk), .ARESET(areset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // ---------------- slave model ----------------
  logic [31:0] s_regs [4];
  logic        got_aw, got_w;
  logic [3:0]  s_awaddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  int          aw_wait;
  int          aw_stall = 0;
  logic        hold_b = 1'b0;
  logic        rd_err_en = 1'b0;
  logic        aw_hs, w_hs, a_ok, d_ok;
  logic [3:0]  eff_addr;
  logic [31:0] eff_data;
  logic [3:0]  eff_strb;

  assign awready  = (aw_wait >= aw_stall);
  assign wready   = 1'b1;
  assign arready  = 1'b1;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign a_ok     = got_aw || aw_hs;
  assign d_ok     = got_w || w_hs;
  assign eff_addr = got_aw ? s_awaddr : awaddr;
  assign eff_data = got_w ? s_wdata : wdata;
  assign eff_strb = got_w ? s_wstrb : wstrb;

  always @(posedge clk) begin
    if (areset) begin
      for (int i = 0; i < 4; i++) s_regs[i] <= '0;
      got_aw <= 1'b0; got_w <= 1'b0; aw_wait <= 0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (aw_hs) aw_wait <= 0;
      else if (awvalid) aw_wait <= aw_wait + 1;
      if (a_ok && d_ok && !bvalid && !hold_b) begin
        for (int b = 0; b < 4; b++)
          if (eff_strb[b]) s_regs[eff_addr[3:2]][8*b +: 8] <= eff_data[8*b +: 8];
        bvalid <= 1'b1; bresp <= 2'b00; got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        if (aw_hs) begin got_aw <= 1'b1; s_awaddr <= awaddr; end
        if (w_hs)  begin got_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready && !rvalid) begin
        rvalid <= 1'b1;
        if (rd_err_en && araddr == 4'hC) begin
          rdata <= 32'hDEAD_BEEF; rresp <= 2'b10;
        end else begin
          rdata <= s_regs[araddr[3:2]]; rresp <= 2'b00;
        end
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int aw_cycles, w_cycles, b_hs_cnt, rsp_cnt;
  logic [NR-1:0] prev_valid = '0, prev_ready = '0;

  always @(negedge clk) begin
    #2;
    if (!areset) begin
      if (awvalid) aw_cycles++;
      if (wvalid) w_cycles++;
      if (bvalid && bready) b_hs_cnt++;
      if (|rsp_valid) rsp_cnt++;
      for (int k = 0; k < NR; k++)
        if (prev_valid[k] && !prev_ready[k] && !req_valid[k]) begin
          bad++;
          $display("FAIL req_valid_protocol: requester %0d dropped valid without req_ready", k);
        end
    end
    prev_valid = req_valid;
    prev_ready = req_ready;
  end

  task automatic clear_counts();
    aw_cycles = 0; w_cycles = 0; b_hs_cnt = 0; rsp_cnt = 0;
  endtask

  task automatic drive_req(input int k, input logic wr, input logic [3:0] addr,
                           input logic [31:0] data);
    req_valid[k]        = 1'b1;
    req_write[k]        = wr;
    req_addr[k*4 +: 4]  = addr;
    req_wdata[k*32 +: 32] = data;
    req_wstrb[k*4 +: 4] = 4'hF;
  endtask

  // One full command/response exchange for requester k with bounded waits.
  task automatic run_txn(input int k, input logic wr, input logic [3:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_resp, input string name);
    int n;
    logic [NR-1:0] oh;
    oh = '0; oh[k] = 1'b1;
    @(negedge clk);
    drive_req(k, wr, addr, data);
    #1; n = 0;
    while (req_ready !== oh && n < 20) begin @(negedge clk); #1; n++; end
    total++;
    if (req_ready !== oh) begin
      bad++; $display("FAIL %s_accept: req_ready=%b expected %b", name, req_ready, oh);
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    #1; n = 0;
    while (rsp_valid === '0 && n < 50) begin @(negedge clk); #1; n++; end
    total++;
    if (rsp_valid !== oh || rsp_resp !== exp_resp || rsp_rdata !== exp_rdata) begin
      bad++;
      $display("FAIL %s_rsp: rsp_valid=%b resp=%b rdata=%h expected %b %b %h",
               name, rsp_valid, rsp_resp, rsp_rdata, oh, exp_resp, exp_rdata);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clk);
    #1; total++;
    if ({awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid,
         rsp_rdata, rsp_resp, busy} !== '0) begin
      bad++; $display("FAIL reset_in: aw=%b w=%b b=%b ar=%b r=%b rdy=%b rsp=%b busy=%b expected all 0",
                      awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid, busy);
    end
    @(negedge clk); areset = 1'b0;
    #1; total++;
    if ({awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid,
         rsp_rdata, rsp_resp, busy} !== '0) begin
      bad++; $display("FAIL reset_out: aw=%b w=%b b=%b ar=%b r=%b rdy=%b rsp=%b busy=%b expected all 0",
                      awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive_req(0, 1'b1, 4'h0, 32'h0000_0001);
    #1; total++;
    if (req_ready !== 2'b01) begin
      bad++; $display("FAIL wr_c0_ready: req_ready=%b expected 01", req_ready);
    end
    @(negedge clk); req_valid[0] = 1'b0;
    #1; total++;
    if ({awvalid, wvalid, awaddr, wdata, wstrb, awprot, busy} !==
        {1'b1, 1'b1, 4'h0, 32'h0000_0001, 4'hF, 3'b000, 1'b1}) begin
      bad++; $display("FAIL wr_c1_awvw: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h prot=%b busy=%b expected 1 1 0 00000001 f 000 1",
                      awvalid, wvalid, awaddr, wdata, wstrb, awprot, busy);
    end
    @(negedge clk); #1; total++;
    if ({bready, bvalid, awvalid, wvalid} !== 4'b1100) begin
      bad++; $display("FAIL wr_c2_b: bready,bvalid,awvalid,wvalid=%b expected 1100",
                      {bready, bvalid, awvalid, wvalid});
    end
    @(negedge clk); #1; total++;
    if ({rsp_valid, rsp_resp, rsp_rdata, busy} !== {2'b01, 2'b00, 32'h0, 1'b1}) begin
      bad++; $display("FAIL wr_c3_rsp: rsp_valid=%b resp=%b rdata=%h busy=%b expected 01 00 0 1",
                      rsp_valid, rsp_resp, rsp_rdata, busy);
    end
    @(negedge clk); #1; total++;
    if ({rsp_valid, busy} !== 3'b000) begin
      bad++; $display("FAIL wr_c4_idle: rsp_valid=%b busy=%b expected 00 0", rsp_valid, busy);
    end
    run_txn(0, 1'b0, 4'h0, 32'h0, 32'h0000_0001, 2'b00, "rd0");
  endtask

  task automatic test_all_regs();
    for (int i = 0; i < 4; i++)
      run_txn(i % 2, 1'b1, 4'(i * 4), 32'(i + 1), 32'h0, 2'b00, $sformatf("wr_reg%0d", i));
    for (int i = 0; i < 4; i++)
      run_txn((i + 1) % 2, 1'b0, 4'(i * 4), 32'h0, 32'(i + 1), 2'b00, $sformatf("rd_reg%0d", i));
  endtask

  task automatic test_error_path();
    rd_err_en = 1'b1;
    run_txn(0, 1'b0, 4'hC, 32'h0, 32'hDEAD_BEEF, 2'b10, "rd_err");
    rd_err_en = 1'b0;
    run_txn(1, 1'b0, 4'h4, 32'h0, 32'h0000_0002, 2'b00, "rd_after_err");
  endtask

  task automatic test_contention();
    int cnt [NR];
    int order[$];
    int n, busy_err, got;
    logic [NR-1:0] gnow;
    @(negedge clk);
    areset = 1'b1;
    drive_req(0, 1'b1, 4'h0, 32'hA0);
    drive_req(1, 1'b1, 4'h4, 32'hB0);
    repeat (2) @(negedge clk);
    areset = 1'b0;
    cnt[0] = 0; cnt[1] = 0; n = 0; busy_err = 0;
    #1;
    while (order.size() < 6 && n < 200) begin
      gnow = req_ready;
      if (gnow == 2'b01) order.push_back(0);
      else if (gnow == 2'b10) order.push_back(1);
      else if (busy !== 1'b1) busy_err++;
      @(negedge clk);
      for (int k = 0; k < NR; k++)
        if (gnow[k]) begin
          cnt[k]++;
          if (cnt[k] < 3) req_wdata[k*32 +: 32] = (k == 0 ? 32'hA0 : 32'hB0) + 32'(cnt[k]);
          else req_valid[k] = 1'b0;
        end
      #1; n++;
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < order.size()) ? order[i] : -1;
      total++;
      if (got != i % 2) begin
        bad++; $display("FAIL cont_grant%0d: granted=%0d expected %0d", i, got, i % 2);
      end
    end
    total++;
    if (busy_err != 0) begin
      bad++; $display("FAIL cont_busy: busy low in %0d non-accept cycles, expected 0", busy_err);
    end
    n = 0;
    while (rsp_valid === '0 && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk); #1;
    total++;
    if (s_regs[0] !== 32'hA2 || s_regs[1] !== 32'hB2) begin
      bad++; $display("FAIL cont_data: reg0=%h reg1=%h expected 000000a2 000000b2", s_regs[0], s_regs[1]);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    aw_stall = 5;
    clear_counts();
    run_txn(1, 1'b1, 4'h8, 32'h55, 32'h0, 2'b00, "bp");
    repeat (2) @(negedge clk);
    #3; total++;
    if (aw_cycles != 6 || w_cycles != 1 || b_hs_cnt != 1 || rsp_cnt != 1) begin
      bad++; $display("FAIL bp_counts: aw=%0d w=%0d b=%0d rsp=%0d expected 6 1 1 1",
                      aw_cycles, w_cycles, b_hs_cnt, rsp_cnt);
    end
    aw_stall = 0;
  endtask

  task automatic test_reset_midop();
    int n;
    @(negedge clk);
    hold_b = 1'b1;
    drive_req(0, 1'b1, 4'h0, 32'h77);
    #1; n = 0;
    while (req_ready !== 2'b01 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk); req_valid[0] = 1'b0;
    #1; n = 0;
    while (bready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    total++;
    if (bready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_wr_resp: bready=%b expected 1", bready);
    end
    repeat (2) @(negedge clk);
    clear_counts();
    areset = 1'b1;
    @(negedge clk); #1; total++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, req_ready, busy} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: aw=%b w=%b ar=%b b=%b r=%b rsp=%b rdy=%b busy=%b expected all 0",
                      awvalid, wvalid, arvalid, bready, rready, rsp_valid, req_ready, busy);
    end
    @(negedge clk); areset = 1'b0; hold_b = 1'b0;
    repeat (3) @(negedge clk);
    #3; total++;
    if (rsp_cnt != 0) begin
      bad++; $display("FAIL rst_mid_no_rsp: rsp pulses=%0d expected 0", rsp_cnt);
    end
    run_txn(1, 1'b1, 4'h8, 32'h99, 32'h0, 2'b00, "post_reset");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_regs();
    test_error_path();
    test_contention();
    test_backpressure();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit, t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_axil_rr_arbiter.md
Name: led_axil_rr_arbiter

Overview:
Round-robin arbiter that shares one AXI4-Lite master port between NUM_REQ simple command requesters. Typical requesters are the PS-side pattern loader and a button/timer pattern engine, and the shared target is the myip_LED register slave (4 x 32-bit registers at 0x0-0xC). The arbiter serialises requests, runs one complete AXI4-Lite write or read per grant, and returns the response to the granted requester. Only one transaction is outstanding at any time.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 4, AXI address width; matches the LED slave register space
DATA_WIDTH, 32, AXI data width; only 32 is supported

Ports:
ACLK  in  1  the single clock; all logic is rising-edge
ARESET  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester command valid; held until the matching req_ready
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k is at [k*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_wstrb  in  NUM_REQ*4  packed byte strobes
req_ready  out  NUM_REQ  one-hot, 1-cycle pulse when a command is accepted
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse when a response is returned
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_resp  out  2  BRESP or RRESP, valid with rsp_valid
busy  out  1  high from accept until the response cycle, inclusive
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master channels (ADDR_WIDTH/DATA_WIDTH)

Behaviour:
- Reset values:
  - All AXI VALID/READY outputs = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_resp = 0; busy = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- Reset is honoured in any state. The FSM returns to IDLE and outputs drop the next edge, with no response issued. The slave shares ARESET, so abandoning a transaction is legal system-wide.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - If any req_valid is high, grant g = the first set bit searching upward from last_grant+1, modulo NUM_REQ.
  - Register the command and pulse req_ready[g].
  - Next state is WR_ADDR_DATA if req_write[g], else RD_ADDR.
- WR_ADDR_DATA:
  - AWVALID and WVALID assert together on entry.
  - Each VALID drops independently on its own handshake.
  - Leave for WR_RESP when both handshakes are done, including when they complete in the same cycle.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP and go to IDLE.
- RD_ADDR: ARVALID = 1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA/RRESP and go to IDLE.
- Response timing:
  - rsp_valid[g] pulses the cycle after the B/R handshake, with rsp_rdata/rsp_resp registered.
  - On write responses, rsp_rdata = 0.
  - last_grant = g is updated at the same time.
- IDLE may accept the next command in the same cycle as a rsp_valid pulse.
- AWPROT = ARPROT = 3'b000. Address and data outputs are stable while VALID is high.
- Minimum latency with zero-wait slave: accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, rsp_valid at cycle 3.
- Fairness: under continuous contention from all requesters, grants rotate strictly. No requester waits more than NUM_REQ-1 transactions.
- BRESP/RRESP of SLVERR or DECERR is passed through unchanged. No retry.
- req_valid deasserted before req_ready is a protocol violation. The bench asserts on it; RTL behaviour is undefined.

Decomposition:
- Package led_axil_arb_pkg holds:
  - state_t enum
  - AXI response constants (OKAY=2'b00, EXOKAY, SLVERR, DECERR)
  - PROT_DEFAULT
- Sub-module rr_grant holds the combinational round-robin priority search and the registered last_grant pointer (NUM_REQ parameter).

Test Plan:
- Write then read: req0 writes 0x00000001 to 0x0 -> AWADDR=0x0, WDATA=0x1, WSTRB=0xF, rsp_valid[0] at cycle 3 with resp 00. req0 reads 0x0 -> rsp_rdata=0x00000001.
- All four registers: write 0x1..0x4 to 0x0/0x4/0x8/0xC, then read back -> read data matches 0x1..0x4 in order, all resp 00.
- Contention: req0 and req1 both valid from the first cycle after reset, each with 3 back-to-back writes -> grant order 0,1,0,1,0,1. busy stays high except for IDLE accept cycles.
- Backpressure: slave holds AWREADY low for 5 cycles while WREADY=1 -> WVALID high for exactly 1 cycle, AWVALID high for 6 cycles, exactly one BREADY handshake, one rsp_valid.
- Error path: slave answers a read of 0xC with RRESP=2'b10 -> rsp_resp=2'b10 to the granted requester, and the next request proceeds normally.
- Reset mid-operation: assert ARESET during WR_RESP (BVALID withheld) -> next edge all VALIDs=0, no rsp_valid, and after release req1 alone is granted normally.
